// File: rtl/rf_buf_pkg.sv
// rf_buf_pkg: shared types and default widths for the RF buffer arbiter
package rf_buf_pkg;
  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_BURST  = 64;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} strm_state_t;
  typedef enum logic {GNT_CPU, GNT_STRM} gnt_t;
endpackage

// File: rtl/rf_buffer_arbiter_if.sv
// rf_buffer_arbiter_if: CPU, stream and buffer signals of the RF buffer arbiter
interface rf_buffer_arbiter_if #(
  parameter int ADDR_WIDTH = rf_buf_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = rf_buf_pkg::DATA_WIDTH,
  parameter int LEN_W      = $clog2(rf_buf_pkg::MAX_BURST) + 1
);
  logic                  cpu_req_valid;
  logic                  cpu_req_write;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic [DATA_WIDTH-1:0] cpu_req_wdata;
  logic                  cpu_req_ready;
  logic                  cpu_rsp_valid;
  logic [DATA_WIDTH-1:0] cpu_rsp_rdata;
  logic                  strm_start;
  logic                  strm_write;
  logic [ADDR_WIDTH-1:0] strm_base;
  logic [LEN_W-1:0]      strm_len;
  logic [DATA_WIDTH-1:0] strm_wdata;
  logic                  strm_wdata_ready;
  logic                  strm_rsp_valid;
  logic [DATA_WIDTH-1:0] strm_rdata;
  logic                  strm_busy;
  logic                  strm_done;
  logic                  buf_read;
  logic                  buf_write;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_data_in;
  logic [DATA_WIDTH-1:0] buf_data_out;
  modport master (
    output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
    output strm_start, strm_write, strm_base, strm_len, strm_wdata, buf_data_out,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    input  strm_wdata_ready, strm_rsp_valid, strm_rdata, strm_busy, strm_done,
    input  buf_read, buf_write, buf_addr, buf_data_in
  );
  modport slave (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
    input  strm_start, strm_write, strm_base, strm_len, strm_wdata, buf_data_out,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    output strm_wdata_ready, strm_rsp_valid, strm_rdata, strm_busy, strm_done,
    output buf_read, buf_write, buf_addr, buf_data_in
  );
endinterface

// File: rtl/rf_burst_addr_gen.sv
// rf_burst_addr_gen: burst address counter with power-of-two wrap and remaining-beat counter
module rf_burst_addr_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_W      = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [LEN_W-1:0]      i_len,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]      r_remaining;
  // load on burst start, advance one word per issued beat; the adder wraps naturally
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_base;
      r_remaining <= i_len;
    end else if (i_step) begin
      r_addr      <= r_addr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  assign o_addr = r_addr;
  assign o_last = r_remaining == LEN_W'(1);
endmodule

// File: rtl/rf_buffer_arbiter.sv
// rf_buffer_arbiter: shares the single-port RF buffer between the CPU and the burst stream engine
module rf_buffer_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 64
) (
  input logic clk,
  input logic reset_n,
  rf_buffer_arbiter_if.slave bus
);
  import rf_buf_pkg::*;
  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  strm_state_t           r_state;
  gnt_t                  r_last_gnt;
  gnt_t                  r_rd_owner;
  logic                  r_rd_pending;
  logic                  r_dir;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LEN_W-1:0]      w_len;
  logic                  w_last;
  logic                  w_load;
  logic                  w_cpu_req;
  logic                  w_strm_req;
  logic                  w_gnt_cpu;
  logic                  w_gnt_strm;
  logic                  w_rd;
  assign w_len      = (bus.strm_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : bus.strm_len;
  assign w_load     = (r_state == S_IDLE) && bus.strm_start;
  assign w_cpu_req  = bus.cpu_req_valid && reset_n;
  assign w_strm_req = r_state == S_RUN;
  assign w_gnt_cpu  = w_cpu_req && (!w_strm_req || r_last_gnt == GNT_STRM);
  assign w_gnt_strm = w_strm_req && (!w_cpu_req || r_last_gnt == GNT_CPU);
  assign w_rd       = w_gnt_cpu ? !bus.cpu_req_write : (w_gnt_strm && !r_dir);
  rf_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_W)) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_base  (bus.strm_base),
    .i_len   (w_len),
    .i_step  (w_gnt_strm),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );
  // stream burst sequencer; busy/done are registered alongside the state they describe
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else
      case (r_state)
        S_IDLE: if (bus.strm_start) begin
          r_dir   <= bus.strm_write;
          r_state <= (w_len == '0) ? S_DONE : S_RUN;
          r_busy  <= 1'b1;
          r_done  <= w_len == '0;
        end
        S_RUN: if (w_gnt_strm && w_last) begin
          r_state <= r_dir ? S_DONE : S_DRAIN;
          r_done  <= r_dir;
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
  // round-robin history and read-return tracking for the 1-cycle buffer latency
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_last_gnt   <= GNT_STRM;
      r_rd_pending <= 1'b0;
      r_rd_owner   <= GNT_CPU;
    end else begin
      if (w_gnt_cpu || w_gnt_strm) r_last_gnt <= w_gnt_cpu ? GNT_CPU : GNT_STRM;
      r_rd_pending <= w_rd;
      r_rd_owner   <= w_gnt_strm ? GNT_STRM : GNT_CPU;
    end
  assign bus.buf_read         = w_rd;
  assign bus.buf_write        = w_gnt_cpu ? bus.cpu_req_write : (w_gnt_strm && r_dir);
  assign bus.buf_addr         = w_gnt_cpu ? bus.cpu_req_addr : w_gnt_strm ? w_addr : '0;
  assign bus.buf_data_in      = w_gnt_cpu ? bus.cpu_req_wdata : w_gnt_strm ? bus.strm_wdata : '0;
  assign bus.cpu_req_ready    = w_gnt_cpu;
  assign bus.strm_wdata_ready = w_gnt_strm && r_dir;
  assign bus.cpu_rsp_valid    = r_rd_pending && r_rd_owner == GNT_CPU;
  assign bus.strm_rsp_valid   = r_rd_pending && r_rd_owner == GNT_STRM;
  assign bus.cpu_rsp_rdata    = bus.cpu_rsp_valid ? bus.buf_data_out : '0;
  assign bus.strm_rdata       = bus.strm_rsp_valid ? bus.buf_data_out : '0;
  assign bus.strm_busy        = r_busy;
  assign bus.strm_done        = r_done;
endmodule
